async_fifo_gray: RTL and testbench

ASYNC_FIFO_GRAY -- requirements
Module: async_fifo_gray

---
 rtl/async_fifo_gray.sv | 137 +++++++++++++
 tb/tb_async_fifo_gray.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossing.
// Write side resets on rst; read side resets on a synchronized copy of it.
module async_fifo_gray #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             wr_clk,
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             almost_full,
  output logic [AW:0]      wr_count,
  output logic             overflow,
  input  logic             clr_ovf,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      rd_count,
  output logic             underflow,
  input  logic             clr_udf
);

  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wbin, wgray, wbin_nx, wgray_nx, wcnt_nx;
  logic [AW:0] rbin, rgray, rbin_nx, rgray_nx, rcnt_nx;
  logic [AW:0] rq [SYNC_STAGES];
  logic [AW:0] wq [SYNC_STAGES];
  logic [AW:0] rgray_s, wgray_s;
  logic [SYNC_STAGES-1:0] rst_sr;
  logic rd_rst, wr_acc, rd_acc;

  assign rgray_s  = rq[SYNC_STAGES-1];
  assign wr_acc   = wr_en & ~full & ~rst;
  assign wbin_nx  = wbin + (AW+1)'(wr_acc);
  assign wgray_nx = bin2gray(wbin_nx);
  assign wcnt_nx  = wbin_nx - gray2bin(rgray_s);

  always_ff @(posedge wr_clk) begin
    if (wr_acc)
      mem[wbin[AW-1:0]] <= wdata;
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wbin        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++)
        rq[i] <= '0;
    end else begin
      rq[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++)
        rq[i] <= rq[i-1];
      wbin        <= wbin_nx;
      wgray       <= wgray_nx;
      // full: next pointer one lap ahead of the synchronized read pointer
      full        <= (wgray_nx ==
                      {~rgray_s[AW -: 2], rgray_s[AW-2:0]});
      wr_count    <= wcnt_nx;
      almost_full <= (wcnt_nx >= AF_L);
      if (wr_en && full)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    rst_sr <= {rst_sr[SYNC_STAGES-2:0], rst};
  end

  assign rd_rst   = rst_sr[SYNC_STAGES-1];
  assign wgray_s  = wq[SYNC_STAGES-1];
  assign rd_acc   = rd_en & ~empty & ~rd_rst;
  assign rbin_nx  = rbin + (AW+1)'(rd_acc);
  assign rgray_nx = bin2gray(rbin_nx);
  assign rcnt_nx  = gray2bin(wgray_s) - rbin_nx;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rbin         <= '0;
      rgray        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++)
        wq[i] <= '0;
    end else begin
      wq[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++)
        wq[i] <= wq[i-1];
      rbin         <= rbin_nx;
      rgray        <= rgray_nx;
      empty        <= (rgray_nx == wgray_s);
      rd_count     <= rcnt_nx;
      almost_empty <= (rcnt_nx <= AE_L);
      rdata_valid  <= rd_acc;
      if (rd_acc)
        rdata <= mem[rbin[AW-1:0]];
      if (rd_en && empty)
        underflow <= 1'b1;
      else if (clr_udf)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed and randomized checks of async_fifo_gray
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_async_fifo_gray;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int SS = 2;
  localparam int AW = 4;

  logic          wr_clk = 1'b0;
  logic          rd_clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  wdata;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_count;
  logic          overflow;
  logic          clr_ovf;
  logic          rd_en;
  logic [W-1:0]  rdata;
  logic          rdata_valid;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;
  logic          underflow;
  logic          clr_udf;

  realtime wr_half = 5.0;
  realtime rd_half = 8.5;

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  async_fifo_gray #(
    .WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS),
    .AF_LEVEL(D-2), .AE_LEVEL(2)
  ) dut (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
    .wr_en(wr_en), .wdata(wdata), .full(full),
    .almost_full(almost_full), .wr_count(wr_count),
    .overflow(overflow), .clr_ovf(clr_ovf),
    .rd_en(rd_en), .rdata(rdata),
    .rdata_valid(rdata_valid), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count),
    .underflow(underflow), .clr_udf(clr_udf)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_d;
  int pushes, rd_acc_n, got;
  logic prev_acc, af_seen;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    wr_en = 1'b0; wdata = '0; clr_ovf = 1'b0;
    rd_en = 1'b0; clr_udf = 1'b0; rst = 1'b1;
    repeat (10) @(negedge wr_clk);
    rst = 1'b0;
    repeat (6) @(negedge rd_clk);

    // reset state
    @(negedge wr_clk);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge rd_clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_valid", 32'(rdata_valid), 32'd0);

    // read from empty
    rd_en = 1'b1;
    @(negedge rd_clk);
    rd_en = 1'b0;
    chk("udf_set", 32'(underflow), 32'd1);
    chk("udf_valid", 32'(rdata_valid), 32'd0);
    chk("udf_rdata", 32'(rdata), 32'd0);
    clr_udf = 1'b1;
    @(negedge rd_clk);
    clr_udf = 1'b0;
    chk("udf_clr", 32'(underflow), 32'd0);

    // 17 writes, no reads; 17th collides with clr_ovf
    @(negedge wr_clk);
    for (int i = 0; i < 17; i++) begin
      if (i == 13) chk("af_at_13", 32'(almost_full), 32'd0);
      if (i == 14) begin
        chk("af_at_14", 32'(almost_full), 32'd1);
        chk("wr_count_14", 32'(wr_count), 32'd14);
      end
      if (i == 15) chk("full_at_15", 32'(full), 32'd0);
      if (i == 16) begin
        chk("full_at_16", 32'(full), 32'd1);
        chk("wr_count_16", 32'(wr_count), 32'd16);
        chk("ovf_before", 32'(overflow), 32'd0);
      end
      wr_en = 1'b1;
      wdata = 8'(i);
      clr_ovf = (i == 16);
      if (i < 16) model_q.push_back(8'(i));
      @(negedge wr_clk);
    end
    wr_en = 1'b0;
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("full_hold", 32'(full), 32'd1);
    clr_ovf = 1'b1;
    @(negedge wr_clk);
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // read back
    for (int k = 0; k < 20; k++) begin
      @(negedge rd_clk);
      if (rd_count == 5'd16) break;
    end
    chk("rd_count_fill", 32'(rd_count), 32'd16);
    chk("empty_fill", 32'(empty), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      @(negedge rd_clk);
      exp_d = model_q.pop_front();
      chk("rb_valid", 32'(rdata_valid), 32'd1);
      chk("rb_data", 32'(rdata), 32'(exp_d));
      chk("rb_count", 32'(rd_count), 32'(15 - i));
      chk("rb_aempty", 32'(almost_empty), 32'((15 - i) <= 2));
    end
    rd_en = 1'b0;
    chk("rb_empty", 32'(empty), 32'd1);
    @(negedge rd_clk);
    chk("rb_valid_drop", 32'(rdata_valid), 32'd0);
    chk("rb_no_udf", 32'(underflow), 32'd0);

    // reset mid-operation
    @(negedge wr_clk);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wdata = 8'(8'h30 + i);
      @(negedge wr_clk);
    end
    wr_en = 1'b0;
    chk("pre_rst_wr_count", 32'(wr_count), 32'd5);
    repeat (5) @(negedge rd_clk);
    chk("pre_rst_empty", 32'(empty), 32'd0);
    chk("pre_rst_rd_count", 32'(rd_count), 32'd5);
    @(negedge wr_clk);
    rst = 1'b1;
    wr_en = 1'b1;
    wdata = 8'hEE;
    fork
      begin
        @(negedge wr_clk);
        chk("rst_mid_full", 32'(full), 32'd0);
        chk("rst_mid_wr_count", 32'(wr_count), 32'd0);
      end
      begin
        for (int j = 0; j < SS + 1; j++) begin
          @(negedge rd_clk);
          if (empty) break;
        end
        chk("rst_mid_empty", 32'(empty), 32'd1);
      end
    join
    repeat (8) @(negedge wr_clk);
    wr_en = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge rd_clk);
    @(negedge wr_clk);
    chk("rst_drop_writes", 32'(wr_count), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);

    // single word after reset, with empty latency
    wr_en = 1'b1;
    wdata = 8'hA5;
    @(posedge wr_clk);
    #1 wr_en = 1'b0;
    for (int j = 0; j < SS + 2; j++) begin
      @(posedge rd_clk);
      #1;
      if (!empty) break;
    end
    chk("first_wr_empty", 32'(empty), 32'd0);
    @(negedge rd_clk);
    rd_en = 1'b1;
    @(negedge rd_clk);
    rd_en = 1'b0;
    chk("a5_valid", 32'(rdata_valid), 32'd1);
    chk("a5_data", 32'(rdata), 32'h0A5);
    chk("a5_empty", 32'(empty), 32'd1);

    // randomized streaming at 7 ns / 13 ns
    wr_half = 3.5;
    rd_half = 6.5;
    repeat (4) @(negedge rd_clk);
    pushes = 0;
    rd_acc_n = 0;
    got = 0;
    prev_acc = 1'b0;
    af_seen = 1'b0;
    fork
      begin
        for (int c = 0; c < 3000 && pushes < 100; c++) begin
          @(negedge wr_clk);
          if (almost_full) af_seen = 1'b1;
          chk("st_af_rule", 32'(almost_full), 32'(wr_count >= 14));
          chk("st_wr_bound", 32'((int'(wr_count) >= pushes - rd_acc_n)
                && (wr_count <= 5'd16)), 32'd1);
          if (!full && $urandom_range(0, 3) != 0) begin
            wr_en = 1'b1;
            wdata = 8'($urandom);
            model_q.push_back(wdata);
            pushes++;
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
      end
      begin
        for (int c = 0; c < 3000 && got < 100; c++) begin
          @(negedge rd_clk);
          chk("st_valid_rule", 32'(rdata_valid), 32'(prev_acc));
          if (rdata_valid) begin
            if (model_q.size() == 0) begin
              chk("st_extra_word", 32'd1, 32'd0);
            end else begin
              exp_d = model_q.pop_front();
              chk("st_data", 32'(rdata), 32'(exp_d));
            end
            got++;
          end
          chk("st_ae_rule", 32'(almost_empty), 32'(rd_count <= 2));
          chk("st_rd_bound",
              32'(int'(rd_count) <= pushes - rd_acc_n), 32'd1);
          prev_acc = !empty && ($urandom_range(0, 1) == 1);
          rd_en = prev_acc;
          if (prev_acc) rd_acc_n++;
        end
        @(negedge rd_clk);
        rd_en = 1'b0;
      end
    join
    repeat (6) @(negedge rd_clk);
    chk("st_pushes", 32'(pushes), 32'd100);
    chk("st_got", 32'(got), 32'd100);
    chk("st_model_drained", 32'(model_q.size()), 32'd0);
    chk("st_af_seen", 32'(af_seen), 32'd1);
    chk("st_empty_end", 32'(empty), 32'd1);
    chk("st_rd_count_end", 32'(rd_count), 32'd0);
    chk("st_no_ovf", 32'(overflow), 32'd0);
    chk("st_no_udf", 32'(underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
